// File: rtl/trace_capture_ctrl_if.sv
// Control/sensor/BRAM-write bundle for trace_capture_ctrl; master = control side, slave = controller.
interface trace_capture_ctrl_if #(
  parameter int AW      = 9,
  parameter int DW      = 7,
  parameter int DELAY_W = 8
);
  logic               arm;
  logic               trig_async;
  logic [DELAY_W-1:0] delay;
  logic [DW-1:0]      sample_in;
  logic               bram_we;
  logic [AW-1:0]      bram_waddr;
  logic [7:0]         bram_wdata;
  logic               busy;
  logic               done;
  logic               missed;

  modport master (
    output arm, trig_async, delay, sample_in,
    input  bram_we, bram_waddr, bram_wdata, busy, done, missed
  );

  modport slave (
    input  arm, trig_async, delay, sample_in,
    output bram_we, bram_waddr, bram_wdata, busy, done, missed
  );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Arm -> trigger edge -> delay -> DEPTH BRAM writes; first write 2+delay clks after trigger sample, no backpressure.
// Define TRACE_DECIM_EN to write one summed byte per 2^DEC_LOG2-sample window instead of one per sample.
module trace_capture_ctrl #(
  parameter int DEPTH    = 56,
  parameter int AW       = 9,
  parameter int DW       = 7,
`ifdef TRACE_DECIM_EN
  parameter int DEC_LOG2 = 1,
`endif
  parameter int DELAY_W  = 8
) (
  input logic                 clk,
  input logic                 rst,
  trace_capture_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_DELAY   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic               s1, s2, s3;
  logic               trig_edge;
  logic [DELAY_W-1:0] cnt;
  logic               we_q;
  logic [AW-1:0]      waddr_q;
  logic [7:0]         wdata_q;
  logic               busy_q;
  logic               done_q;
  logic               missed_q;
  logic               arm_ok;
  logic               start_cap;
  logic               last_write;

`ifdef TRACE_DECIM_EN
  localparam int SW = DW + DEC_LOG2;
  logic [SW-1:0]       acc;
  logic [SW-1:0]       sum;
  logic [DEC_LOG2-1:0] win;
  assign sum = acc + SW'(bus.sample_in);
`endif

  // Trigger crosses from the AES domain; the third flop makes the edge a single-clk pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.trig_async;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign trig_edge  = s2 & ~s3;
  assign arm_ok     = bus.arm && (state == S_IDLE || state == S_DONE);
  assign start_cap  = (state == S_ARMED && trig_edge && bus.delay == '0) ||
                      (state == S_DELAY && cnt == DELAY_W'(1));
  assign last_write = we_q && (waddr_q == LAST_ADDR);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.arm) state_nxt = S_ARMED;
      S_ARMED:   if (trig_edge) state_nxt = (bus.delay == '0) ? S_CAPTURE : S_DELAY;
      S_DELAY:   if (cnt == DELAY_W'(1)) state_nxt = S_CAPTURE;
      S_CAPTURE: if (last_write) state_nxt = S_DONE;
      S_DONE:    if (bus.arm) state_nxt = S_ARMED;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
`ifdef TRACE_DECIM_EN
      acc      <= '0;
      win      <= '0;
`endif
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == S_ARMED) || (state_nxt == S_DELAY) || (state_nxt == S_CAPTURE);
      done_q <= (state_nxt == S_DONE);

      if (trig_edge && (state == S_DELAY || state == S_CAPTURE))
        missed_q <= 1'b1;
      else if (arm_ok)
        missed_q <= 1'b0;

      if (state == S_ARMED && trig_edge)
        cnt <= bus.delay;
      else if (state == S_DELAY)
        cnt <= cnt - DELAY_W'(1);

      if (arm_ok)
        waddr_q <= '0;

`ifdef TRACE_DECIM_EN
      // Window's first sample is taken on the entry edge; the write lands on the window's last sample.
      if (start_cap) begin
        we_q    <= 1'b0;
        waddr_q <= '0;
        acc     <= SW'(bus.sample_in);
        win     <= DEC_LOG2'(1);
      end else if (state == S_CAPTURE) begin
        if (last_write) begin
          we_q <= 1'b0;
        end else begin
          if (we_q)
            waddr_q <= waddr_q + AW'(1);
          if (win == '1) begin
            we_q    <= 1'b1;
            wdata_q <= sum[SW-1 -: 8];
            acc     <= '0;
            win     <= '0;
          end else begin
            we_q <= 1'b0;
            acc  <= sum;
            win  <= win + DEC_LOG2'(1);
          end
        end
      end
`else
      if (start_cap) begin
        we_q    <= 1'b1;
        waddr_q <= '0;
        wdata_q <= {{(8-DW){1'b0}}, bus.sample_in};
      end else if (state == S_CAPTURE) begin
        if (last_write) begin
          we_q <= 1'b0;
        end else begin
          we_q    <= 1'b1;
          waddr_q <= waddr_q + AW'(1);
          wdata_q <= {{(8-DW){1'b0}}, bus.sample_in};
        end
      end
`endif
    end
  end

  assign bus.bram_we    = we_q;
  assign bus.bram_waddr = waddr_q;
  assign bus.bram_wdata = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.missed     = missed_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl with a write scoreboard (cycle, address, data).
module tb_trace_capture_ctrl;
  localparam int DEPTH = 56;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trace_capture_ctrl_if ifc ();
  trace_capture_ctrl dut (.clk(clk), .rst(rst), .bus(ifc));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit ramp_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int a;
    int d;
  } exp_t;
  exp_t sb[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ramp_on) ifc.sample_in = 7'(cyc + 1);
  endtask

  task automatic arm_pulse();
    ifc.arm = 1'b1;
    step();
    ifc.arm = 1'b0;
  endtask

  // Call right after raising trig_async: first write lands 3+d edges after the current one.
  task automatic push_trace(int d, int val, bit ramp);
    for (int j = 0; j < DEPTH; j++) begin
      exp_t e;
      e.c = cyc + 3 + d + j;
      e.a = j;
      e.d = ramp ? (e.c & 8'h7F) : val;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (ifc.done !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check("done_reached", ifc.done, 1);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic wait_addr(int a);
    int n = 0;
    while (ifc.bram_waddr !== a[8:0] && n < 200) begin
      step();
      n++;
    end
    check("reach_addr", ifc.bram_waddr, a);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_we"},     ifc.bram_we,    0);
    check({tag, "_waddr"},  ifc.bram_waddr, 0);
    check({tag, "_wdata"},  ifc.bram_wdata, 0);
    check({tag, "_busy"},   ifc.busy,       0);
    check({tag, "_done"},   ifc.done,       0);
    check({tag, "_missed"}, ifc.missed,     0);
  endtask

  initial begin
    exp_t e;
    ifc.arm        = 1'b0;
    ifc.trig_async = 1'b0;
    ifc.delay      = '0;
    ifc.sample_in  = '0;

    fork
      forever begin
        @(negedge clk);
        if (ifc.bram_we === 1'b1) begin
          total++;
          assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_write addr=%0d data=%0h expected=no write", ifc.bram_waddr, ifc.bram_wdata);
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("w_cycle", cyc, e.c);
            check("w_addr", ifc.bram_waddr, e.a);
            check("w_data", ifc.bram_wdata, e.d);
          end
        end
      end
    join_none

    #1;
    check_all_zero("reset");
    repeat (3) step();
    rst = 1'b0;
    step();

    // Trigger without arm must not write.
    ifc.trig_async = 1'b1;
    repeat (5) step();
    ifc.trig_async = 1'b0;
    repeat (3) step();
    check("noarm_busy", ifc.busy, 0);
    check("noarm_done", ifc.done, 0);

    // delay 0, ramp data
    ifc.delay = 0;
    arm_pulse();
    check("armed_busy", ifc.busy, 1);
    ramp_on = 1'b1;
    ifc.sample_in = 7'(cyc + 1);
    ifc.trig_async = 1'b1;
    push_trace(0, 0, 1'b1);
    wait_done();
    ramp_on = 1'b0;
    check("t2_busy", ifc.busy, 0);
    check("t2_missed", ifc.missed, 0);
    check("t2_addr_hold", ifc.bram_waddr, DEPTH - 1);
    repeat (3) step();
    check("t2_done_hold", ifc.done, 1);

    // delay 10, constant data
    ifc.trig_async = 1'b0;
    repeat (2) step();
    arm_pulse();
    check("t3_done_clr", ifc.done, 0);
    check("t3_addr_clr", ifc.bram_waddr, 0);
    ifc.delay = 10;
    ifc.sample_in = 7'h2A;
    ifc.trig_async = 1'b1;
    push_trace(10, 8'h2A, 1'b0);
    wait_done();

    // Second edge mid-capture sets missed, capture runs on.
    ifc.trig_async = 1'b0;
    repeat (2) step();
    arm_pulse();
    ifc.delay = 0;
    ifc.sample_in = 7'h33;
    ifc.trig_async = 1'b1;
    push_trace(0, 8'h33, 1'b0);
    repeat (5) step();
    ifc.trig_async = 1'b0;
    wait_addr(20);
    ifc.trig_async = 1'b1;
    repeat (5) step();
    check("t4_missed_mid", ifc.missed, 1);
    wait_done();
    check("t4_missed", ifc.missed, 1);

    // Arm with trigger already high: no capture until a fresh rising edge.
    arm_pulse();
    check("t5_missed_clr", ifc.missed, 0);
    check("t5_done_clr", ifc.done, 0);
    repeat (30) step();
    check("t5_still_busy", ifc.busy, 1);
    check("t5_no_done", ifc.done, 0);
    ifc.trig_async = 1'b0;
    repeat (3) step();
    ifc.delay = 5;
    ifc.sample_in = 7'h11;
    ifc.trig_async = 1'b1;
    push_trace(5, 8'h11, 1'b0);
    wait_done();

    // Reset mid-capture at address 30.
    ifc.trig_async = 1'b0;
    repeat (2) step();
    arm_pulse();
    ifc.delay = 0;
    ifc.sample_in = 7'h55;
    ifc.trig_async = 1'b1;
    push_trace(0, 8'h55, 1'b0);
    wait_addr(30);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    sb.delete();
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    check("post_rst_busy", ifc.busy, 0);

    // Arm and edge in the same IDLE cycle: arm wins, edge is dropped.
    ifc.trig_async = 1'b0;
    repeat (4) step();
    ifc.trig_async = 1'b1;
    repeat (2) step();
    ifc.arm = 1'b1;
    step();
    ifc.arm = 1'b0;
    repeat (10) step();
    check("same_cyc_busy", ifc.busy, 1);
    check("same_cyc_done", ifc.done, 0);
    ifc.trig_async = 1'b0;
    repeat (3) step();
    ifc.trig_async = 1'b1;
    push_trace(0, 8'h55, 1'b0);
    wait_done();
    check("t6_addr_end", ifc.bram_waddr, DEPTH - 1);
    check("t6_missed", ifc.missed, 0);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
